// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer with a one-word output register,
// valid/ready handshake, flush, and a sticky overflow flag.
module sipo_deserializer #(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_serial_in,
  input  logic         i_serial_valid,
  input  logic         i_flush,
  input  logic         i_ready,
  input  logic         i_clr_overflow,
  output logic [N-1:0] o_parallel_out,
  output logic         o_valid,
  output logic         o_busy,
  output logic         o_overflow
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [N-1:0]  out_q, out_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;

  logic          accept;
  logic          complete;
  logic          load;
  logic          drain;

  always_comb begin
    accept   = i_serial_valid & ~i_flush;
    complete = accept & (count_q == CW'(N - 1));
    drain    = valid_q & i_ready;
    load     = complete & (~valid_q | i_ready);

    state_d = state_q;
    count_d = count_q;
    sr_d    = sr_q;

    if (i_flush) begin
      state_d = IDLE;
      count_d = '0;
      sr_d    = '0;
    end else if (accept) begin
      // Shift direction sets where the first bit lands once N bits are in.
      if (MSB_FIRST) sr_d = {sr_q[N-2:0], i_serial_in};
      else           sr_d = {i_serial_in, sr_q[N-1:1]};
      if (complete) begin
        state_d = IDLE;
        count_d = '0;
      end else begin
        state_d = SHIFT;
        count_d = count_q + CW'(1);
      end
    end

    out_d   = load ? sr_d : out_q;
    valid_d = load ? 1'b1 : (drain ? 1'b0 : valid_q);

    // A set on the same edge takes priority over the clear.
    if (complete & valid_q & ~i_ready) ovf_d = 1'b1;
    else if (i_clr_overflow)           ovf_d = 1'b0;
    else                               ovf_d = ovf_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      sr_q    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sr_q    <= sr_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_parallel_out = out_q;
  assign o_valid        = valid_q;
  assign o_busy         = (state_q == SHIFT);
  assign o_overflow     = ovf_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench: MSB-first and LSB-first instances share all stimulus.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sin, sval, flush, ready, clr;
  logic [3:0] m_out, l_out;
  logic       m_valid, m_busy, m_ovf;
  logic       l_valid, l_busy, l_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.N(4), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_rst_n(rst_n), .i_serial_in(sin), .i_serial_valid(sval),
    .i_flush(flush), .i_ready(ready), .i_clr_overflow(clr),
    .o_parallel_out(m_out), .o_valid(m_valid), .o_busy(m_busy), .o_overflow(m_ovf)
  );

  sipo_deserializer #(.N(4), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_serial_in(sin), .i_serial_valid(sval),
    .i_flush(flush), .i_ready(ready), .i_clr_overflow(clr),
    .o_parallel_out(l_out), .o_valid(l_valid), .o_busy(l_busy), .o_overflow(l_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one cycle of serial input, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic b);
    sval = v;
    sin  = b;
    @(posedge clk);
    #1;
    sval = 1'b0;
    sin  = 1'b0;
  endtask

  task automatic send4(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) step(1'b1, w[i]);
  endtask

  initial begin
    rst_n = 1'b0; sin = 1'b0; sval = 1'b0; flush = 1'b0; ready = 1'b1; clr = 1'b0;
    #2;
    chk("rst_m_out",   32'(m_out),   32'h0);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_m_busy",  32'(m_busy),  32'h0);
    chk("rst_m_ovf",   32'(m_ovf),   32'h0);
    chk("rst_l_out",   32'(l_out),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back word 1,0,1,0 with ready high
    step(1'b1, 1'b1);
    chk("b2b_busy_1", 32'(m_busy), 32'h1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("b2b_valid_pre", 32'(m_valid), 32'h0);
    step(1'b1, 1'b0);
    chk("b2b_m_out",   32'(m_out),   32'hA);
    chk("b2b_m_valid", 32'(m_valid), 32'h1);
    chk("b2b_m_busy",  32'(m_busy),  32'h0);
    chk("b2b_l_out",   32'(l_out),   32'h5);
    chk("b2b_l_valid", 32'(l_valid), 32'h1);
    step(1'b0, 1'b0);
    chk("b2b_valid_one_cycle", 32'(m_valid), 32'h0);
    chk("b2b_out_kept", 32'(m_out), 32'hA);

    // Same word with two idle cycles between bits
    step(1'b1, 1'b1);
    step(1'b0, 1'b0); chk("gap_busy_a", 32'(l_busy), 32'h1);
    step(1'b0, 1'b0); chk("gap_busy_b", 32'(l_busy), 32'h1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0); chk("gap_busy_c", 32'(l_busy), 32'h1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0); chk("gap_valid_pre", 32'(l_valid), 32'h0);
    step(1'b1, 1'b0);
    chk("gap_l_out",   32'(l_out),   32'h5);
    chk("gap_l_valid", 32'(l_valid), 32'h1);
    chk("gap_m_out",   32'(m_out),   32'hA);
    step(1'b0, 1'b0);

    // Overflow with consumer stalled
    ready = 1'b0;
    send4(4'b1100);
    chk("ovf_first_m_out", 32'(m_out), 32'hC);
    chk("ovf_first_l_out", 32'(l_out), 32'h3);
    chk("ovf_first_flag",  32'(m_ovf), 32'h0);
    send4(4'b0011);
    chk("ovf_hold_m_out", 32'(m_out),   32'hC);
    chk("ovf_hold_valid", 32'(m_valid), 32'h1);
    chk("ovf_m_flag",     32'(m_ovf),   32'h1);
    chk("ovf_l_flag",     32'(l_ovf),   32'h1);
    chk("ovf_hold_l_out", 32'(l_out),   32'h3);
    step(1'b0, 1'b0);
    chk("ovf_sticky", 32'(m_ovf), 32'h1);
    clr = 1'b1;
    step(1'b0, 1'b0);
    clr = 1'b0;
    chk("ovf_cleared", 32'(m_ovf), 32'h0);
    chk("ovf_valid_after_clr", 32'(m_valid), 32'h1);

    // Drain, then load-and-consume on the same edge
    ready = 1'b1;
    step(1'b0, 1'b0);
    chk("drain_valid", 32'(m_valid), 32'h0);
    ready = 1'b0;
    send4(4'b1111);
    chk("ll_first", 32'(m_out), 32'hF);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("ll_stable", 32'(m_out), 32'hF);
    ready = 1'b1;
    step(1'b1, 1'b0);
    chk("ll_valid",  32'(m_valid), 32'h1);
    chk("ll_m_out",  32'(m_out),   32'h6);
    chk("ll_l_out",  32'(l_out),   32'h6);
    chk("ll_no_ovf", 32'(m_ovf),   32'h0);
    step(1'b0, 1'b0);
    chk("ll_drained", 32'(m_valid), 32'h0);

    // Flush mid-word; bit presented with the flush is discarded
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("fl_busy_pre", 32'(m_busy), 32'h1);
    flush = 1'b1;
    step(1'b1, 1'b1);
    flush = 1'b0;
    chk("fl_busy_post", 32'(m_busy), 32'h0);
    chk("fl_out_kept",  32'(m_out),  32'h6);
    send4(4'b1001);
    chk("fl_m_out", 32'(m_out),   32'h9);
    chk("fl_l_out", 32'(l_out),   32'h9);
    chk("fl_valid", 32'(m_valid), 32'h1);
    step(1'b0, 1'b0);

    // Reset mid-word
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_m_out",  32'(m_out),  32'h0);
    chk("rr_m_busy", 32'(m_busy), 32'h0);
    chk("rr_m_valid",32'(m_valid),32'h0);
    chk("rr_m_ovf",  32'(m_ovf),  32'h0);
    chk("rr_l_out",  32'(l_out),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send4(4'b1001);
    chk("rr_word_m", 32'(m_out),   32'h9);
    chk("rr_word_l", 32'(l_out),   32'h9);
    chk("rr_valid",  32'(m_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 SHALL have parameter N, default 4, giving the word width in bits (N >= 2).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 means the first received bit is word bit N-1, 0 means the first received bit is word bit 0.
REQ-003 SHALL have port i_clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_serial_in, input, 1 bit: serial data bit.
REQ-006 SHALL have port i_serial_valid, input, 1 bit: i_serial_in is sampled this cycle.
REQ-007 SHALL have port i_flush, input, 1 bit: synchronous discard of the partial word.
REQ-008 SHALL have port i_ready, input, 1 bit: consumer accepts o_parallel_out.
REQ-009 SHALL have port o_parallel_out, output, N bits: assembled word.
REQ-010 SHALL have port o_valid, output, 1 bit: o_parallel_out holds an unconsumed word.
REQ-011 SHALL have port o_busy, output, 1 bit: a partial word of 1..N-1 bits is held.
REQ-012 SHALL have port o_overflow, output, 1 bit: sticky flag, set when a completed word was dropped.
REQ-013 SHALL have port i_clr_overflow, input, 1 bit: synchronous clear of o_overflow.

Function
REQ-014 SHALL implement two states:
- IDLE: bit count 0.
- SHIFT: bit count 1..N-1.
REQ-015 SHALL, on an edge with i_serial_valid=1, sample i_serial_in into the shift register and increment the bit counter. With i_serial_valid=0, shift register and counter SHALL hold.
REQ-016 SHALL transition IDLE->SHIFT on the first accepted bit. SHALL stay in SHIFT through bits 2..N-1. On the Nth accepted bit SHALL return to IDLE with count 0 (wrap) and produce a completed word.
REQ-017 SHALL place bits by position: with MSB_FIRST=1, bit k (0-based arrival order) lands at word bit N-1-k. With MSB_FIRST=0, it lands at word bit k.
REQ-018 SHALL load a completed word into the output register on the same edge that samples the Nth bit, when the output register is empty or is drained that cycle (o_valid=1 and i_ready=1). o_valid SHALL then be 1 from the following cycle; latency is 1 cycle after the Nth bit edge.
REQ-019 SHALL consume the held word on an edge with o_valid=1 and i_ready=1. o_valid SHALL clear unless a new word loads on that same edge, in which case o_valid SHALL stay 1 with the new data.
REQ-020 SHALL hold o_parallel_out stable while o_valid=1 and i_ready=0.
REQ-021 SHALL, when a word completes while o_valid=1 and i_ready=0, drop the new word, keep the held word, and set o_overflow (sticky).
REQ-022 SHALL let i_flush=1 force count 0 and state IDLE, discarding the partial word. A bit arriving the same cycle as the flush SHALL be discarded. The output register and o_valid SHALL be unaffected.
REQ-023 SHALL let i_clr_overflow=1 clear o_overflow. If an overflow occurs on the same edge, set SHALL win.
REQ-024 SHALL drive o_busy=1 exactly when in SHIFT.
REQ-025 SHALL have no combinational path from any input to any output; all outputs are registered.

Reset
REQ-026 SHALL, while i_rst_n=0, immediately force: state IDLE, count 0, shift register 0, o_parallel_out 0, o_valid 0, o_busy 0, o_overflow 0.
REQ-027 SHALL, on reset assertion mid-word, lose the partial word. The first bit after release SHALL be treated as bit 0.
REQ-028 SHALL resume normal operation on the first rising edge after i_rst_n deasserts.

Verification (N=4)
REQ-029 SHALL verify: MSB_FIRST=1, i_ready=1, bits 1,0,1,0 on 4 consecutive valid cycles -> o_parallel_out=4'b1010, o_valid=1 for one cycle, starting 1 cycle after the 4th bit.
REQ-030 SHALL verify: MSB_FIRST=0, bits 1,0,1,0 -> o_parallel_out=4'b0101. Also bits with i_serial_valid gaps of 2 idle cycles -> same word, o_busy=1 across the gaps.
REQ-031 SHALL verify: i_ready=0, two words 4'b1100 then 4'b0011 -> o_parallel_out stays 4'b1100, o_overflow=1. Then i_clr_overflow pulse -> o_overflow=0.
REQ-032 SHALL verify: o_valid=1 holding 4'b1111, i_ready=1 on the same edge as the Nth bit of 4'b0110 -> o_valid stays 1, o_parallel_out=4'b0110, o_overflow=0.
REQ-033 SHALL verify: after 2 bits, pulse i_flush, then send 1,0,0,1 -> o_parallel_out=4'b1001. Repeat with i_rst_n low instead of i_flush -> all outputs 0 during reset, same word 4'b1001 after release.
